// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Signed ops run on magnitudes; the signs are applied in the final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign signed_op = ~op[0];
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply step: add multiplicand into the upper half when the LSB is set, then shift right.
  assign add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
  // Restoring divide step on a WIDTH+1 bit partial remainder.
  assign shifted  = {rem, quo[WIDTH-1]};
  assign diff     = shifted - {1'b0, opnd};

  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -quo : quo;
  assign rem_fix  = neg_r ? -rem : rem;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_orig <= '0;
      opnd   <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= signed_op & a[WIDTH-1];
            b_zero <= (b == '0);
            a_orig <= a;
            opnd   <= op[1] ? b_mag : a_mag;
            prod   <= {{WIDTH{1'b0}}, b_mag};
            rem    <= '0;
            quo    <= a_mag;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= {add_sum, prod[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            // Division by zero falls out of the datapath as all-ones quotient; HI reports the raw dividend.
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    longint unsigned up;
    int qi, ri;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; return 64'(p); end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; return up; end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        qi = $signed(x) / $signed(y);
        ri = $signed(x) % $signed(y);
        return {32'(ri), 32'(qi)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain op; 1: re-start and MTHI at cycle 5 while busy; 2: lo_we together with start.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int mode);
    logic [63:0] exp;
    int cycles, busyCnt;
    exp = refModel(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (mode == 2) begin lo_we = 1'b1; wdata = 32'hCAFEF00D; end
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    cycles = 1;
    busyCnt = busy ? 1 : 0;
    checkOutput("busy_after_start", 64'(busy), 64'(1));
    checkOutput("hi_old_during_run", 64'(hi), 64'(expHi));
    checkOutput("lo_old_during_run", 64'(lo), 64'(expLo));
    while (done !== 1'b1 && cycles < 60) begin
      if (cycles == 5 && mode == 1) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        hi_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      cycles++;
      if (busy) busyCnt++;
      if (cycles == 6 && mode == 1) checkOutput("hi_hold_while_busy", 64'(hi), 64'(expHi));
    end
    checkOutput("latency", 64'(cycles), 64'(WIDTH + 2));
    checkOutput("busy_cycles", 64'(busyCnt), 64'(WIDTH + 1));
    checkOutput("hi_result", 64'(hi), 64'(exp[63:32]));
    checkOutput("lo_result", 64'(lo), 64'(exp[31:0]));
    expHi = exp[63:32];
    expLo = exp[31:0];
    @(negedge clk);
    checkOutput("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int doneSeen;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_hi", 64'(hi), 64'(0));
    checkOutput("reset_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd7, 0);
    applyStimulus(2'b10, 32'hFFFFFFF9, 32'd2, 0);
    applyStimulus(2'b11, 32'd100, 32'd7, 0);
    applyStimulus(2'b11, 32'h12345678, 32'd0, 0);
    applyStimulus(2'b10, 32'hF0000001, 32'd0, 0);
    applyStimulus(2'b10, 32'h80000000, 32'hFFFFFFFF, 0);
    applyStimulus(2'b00, 32'h80000000, 32'h80000000, 0);

    $display("[TB] handshake");
    applyStimulus(2'b00, 32'h00012345, 32'hFFFF0001, 1);
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0;
    expHi = 32'hDEADBEEF;
    checkOutput("mthi_idle", 64'(hi), 64'(expHi));
    checkOutput("mthi_lo_kept", 64'(lo), 64'(expLo));
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BADCAFE;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    expHi = 32'h0BADCAFE; expLo = 32'h0BADCAFE;
    checkOutput("mthi_both", 64'(hi), 64'(expHi));
    checkOutput("mtlo_both", 64'(lo), 64'(expLo));
    applyStimulus(2'b11, 32'd1000, 32'd33, 2);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'hFFFFFF00; b = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_hi", 64'(hi), 64'(0));
    checkOutput("midreset_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;
    expHi = '0; expLo = '0;
    doneSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen = 1;
    end
    checkOutput("midreset_no_done", 64'(doneSeen), 64'(0));
    applyStimulus(2'b01, 32'd3, 32'd5, 0);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'($urandom_range(0, 500)); rb = 32'($urandom_range(1, 40)); end
        3: rb = -32'($urandom_range(1, 9));
        default: ;
      endcase
      applyStimulus(ro, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
